// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus independent per-bit debounce FSMs for the board slide switches.
// Outputs are registered; change pulses are held off until the first post-reset window has elapsed.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_STABLE   | synchronized sample matches sw_stable, counter idle at 0
// ST_COUNTING | sample differs from sw_stable, counter tracks the run length
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 3)
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_change,
    output logic             sw_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] VALID_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_t;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] accept;
    logic [CNT_W-1:0] valid_cnt;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        deb_state_t       state;
        logic [CNT_W-1:0] cnt;
        logic             stable_q;

        // Final differing sample of a full window: the level is taken on this edge.
        assign accept[i]    = (state == ST_COUNTING) && (sync2[i] != stable_q) && (cnt == CNT_LAST);
        assign sw_stable[i] = stable_q;

        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                state    <= ST_STABLE;
                cnt      <= '0;
                stable_q <= 1'b0;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (sync2[i] != stable_q) begin
                            state <= ST_COUNTING;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    ST_COUNTING: begin
                        if (sync2[i] == stable_q) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            stable_q <= sync2[i];
                            state    <= ST_STABLE;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Valid timer lands on the same edge as the earliest acceptance of a level present at release.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            valid_cnt <= '0;
            sw_valid  <= 1'b0;
        end else if (!sw_valid) begin
            valid_cnt <= valid_cnt + CNT_W'(1);
            if (valid_cnt == VALID_LAST) begin
                sw_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sw_changed <= '0;
            any_change <= 1'b0;
        end else begin
            sw_changed <= sw_valid ? accept : '0;
            any_change <= sw_valid && (|accept);
        end
    end

endmodule
